// File: rtl/count_wrap_pkg.sv
// Shared constants, the wrap event record and a saturating-increment helper
// for the count wrap logger.
package count_wrap_pkg;

  localparam int TS_W     = 16;
  localparam int SEQ_W    = 8;
  localparam int DROP_W   = 8;
  localparam int DROP_MAX = 255;

  // One logged wrap: when it happened and its running sequence number.
  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [SEQ_W-1:0] seq;
  } wrap_evt_t;

  // Increment that sticks at DROP_MAX instead of rolling over.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == DROP_W'(DROP_MAX)) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/wrap_evt_fifo.sv
// Small first-word-fall-through FIFO. The head entry is visible on dout
// whenever the FIFO is not empty. A push into a full FIFO is accepted when
// a pop happens in the same cycle, because the slot is freed on that edge.
module wrap_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  output logic                     full,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wrap_evt_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      // NOTE: the storage is reset too, so dout reads a defined 0 straight
      // after reset instead of whatever the array powered up with.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let the write to mem[wr_ptr] and the
      // read-pointer advance of a full-FIFO push+pop use pre-edge values.
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/count_wrap_logger.sv
// Watches a free-running counter's output, timestamps every WRAP_VAL -> 0
// wrap, flags illegal jumps and queues wrap events for a valid/ready consumer.
module count_wrap_logger
  import count_wrap_pkg::SEQ_W;
  import count_wrap_pkg::DROP_W;
  import count_wrap_pkg::sat_inc;
#(
  parameter int CNT_W    = 6,
  parameter int WRAP_VAL = 31,
  parameter int TS_W     = 16,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CNT_W-1:0]         count_in,
  input  logic                     count_valid,
  input  logic                     err_clr,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [TS_W-1:0]          evt_ts,
  output logic [SEQ_W-1:0]         evt_seq,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic                     err_jump,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int EVT_W = TS_W + SEQ_W;

  logic [TS_W-1:0]  ts;
  logic [CNT_W-1:0] prev_count;
  logic             prev_vld;
  logic [SEQ_W-1:0] seq;
  logic             wrap;
  logic             jump;
  logic             pop;
  logic             full;
  logic             empty;
  logic             push_ok;
  logic [EVT_W-1:0] fifo_din;
  logic [EVT_W-1:0] fifo_dout;

  // Detection only fires once a previous sample exists; holding a value or
  // stepping by one is legal, the terminal wrap is handled separately.
  assign wrap = count_valid & prev_vld
              & (prev_count == CNT_W'(WRAP_VAL)) & (count_in == '0);
  assign jump = count_valid & prev_vld & ~wrap
              & (count_in != prev_count)
              & (count_in != prev_count + CNT_W'(1));

  assign evt_valid = ~empty;
  assign pop       = evt_valid & evt_ready;
  assign push_ok   = wrap & (~full | pop);
  assign fifo_din  = {ts, seq};
  assign evt_ts    = fifo_dout[EVT_W-1:SEQ_W];
  assign evt_seq   = fifo_dout[SEQ_W-1:0];

  // Free-running timestamp, modulo 2^TS_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts <= '0;
    else        ts <= ts + TS_W'(1);
  end

  // Remember the last valid sample; idle cycles leave it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_count <= '0;
      prev_vld   <= 1'b0;
    end else if (count_valid) begin
      prev_count <= count_in;
      prev_vld   <= 1'b1;
    end
  end

  // Sticky jump flag; a new jump beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err_jump <= 1'b0;
    else if (jump)    err_jump <= 1'b1;
    else if (err_clr) err_jump <= 1'b0;
  end

  // Sequence number advances on every wrap, dropped or not, so gaps expose drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    seq <= '0;
    else if (wrap) seq <= seq + SEQ_W'(1);
  end

  // Saturating count of wraps that found the FIFO full with no pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               drop_cnt <= '0;
    else if (wrap && !push_ok) drop_cnt <= sat_inc(drop_cnt);
  end

  wrap_evt_fifo #(
    .DEPTH (DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wrap),
    .din   (fifo_din),
    .full  (full),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_count_wrap_logger.sv
// Self-checking bench for count_wrap_logger: a table of jump/clear vectors,
// hand-built wrap/FIFO corner sequences and a randomized run, all compared
// against a queue-based reference model.
module tb_count_wrap_logger;
  import count_wrap_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] count_in = '0;
  logic       count_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [15:0] evt_ts;
  logic [7:0] evt_seq;
  logic [7:0] drop_cnt;
  logic       err_jump;
  logic [2:0] fifo_level;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int        m_ts;
  int        m_prev;   // -1 until the first valid sample after reset
  int        m_seq;
  int        m_drop;
  bit        m_err;
  wrap_evt_t m_q[$];

  count_wrap_logger #(
    .CNT_W(6), .WRAP_VAL(31), .TS_W(16), .DEPTH(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .count_in    (count_in),
    .count_valid (count_valid),
    .err_clr     (err_clr),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_ts      (evt_ts),
    .evt_seq     (evt_seq),
    .drop_cnt    (drop_cnt),
    .err_jump    (err_jump),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_ts = 0; m_prev = -1; m_seq = 0; m_drop = 0; m_err = 1'b0;
    m_q.delete();
  endfunction

  // One clock of the behavioural rules, applied to this cycle's inputs.
  function automatic void model_step(input bit cv, input int cin, input bit clr, input bit rdy);
    bit        pop_now;
    bit        wrap_now;
    bit        jump_now;
    wrap_evt_t ev;
    pop_now  = (m_q.size() > 0) && rdy;
    wrap_now = 1'b0;
    jump_now = 1'b0;
    if (cv) begin
      if (m_prev >= 0) begin
        wrap_now = (m_prev == 31) && (cin == 0);
        jump_now = !wrap_now && (cin != m_prev) && (cin != (m_prev + 1) % 64);
      end
      m_prev = cin;
    end
    if (jump_now)   m_err = 1'b1;
    else if (clr)   m_err = 1'b0;
    if (pop_now) void'(m_q.pop_front());
    if (wrap_now) begin
      if (m_q.size() < 4) begin
        ev.ts  = 16'(m_ts);
        ev.seq = 8'(m_seq);
        m_q.push_back(ev);
      end else if (m_drop < 255) begin
        m_drop++;
      end
      m_seq = (m_seq + 1) % 256;
    end
    m_ts = (m_ts + 1) % 65536;
  endfunction

  task automatic compare_model();
    check("evt_valid", evt_valid, (m_q.size() > 0) ? 1 : 0);
    check("fifo_level", fifo_level, m_q.size());
    check("drop_cnt", drop_cnt, m_drop);
    check("err_jump", err_jump, m_err);
    if (m_q.size() > 0) begin
      check("evt_ts", evt_ts, m_q[0].ts);
      check("evt_seq", evt_seq, m_q[0].seq);
    end
  endtask

  // Called at a falling edge: drive, step the model, clock, compare at next fall.
  task automatic cycle(input bit cv, input int cin, input bit clr, input bit rdy);
    count_valid = cv;
    count_in    = 6'(cin);
    err_clr     = clr;
    evt_ready   = rdy;
    model_step(cv, cin, clr, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  // Drives 1..31 then 0 (expects the previous sample to be 0): one wrap.
  task automatic wrap_ramp(input bit rdy);
    for (int v = 1; v <= 31; v++) cycle(1'b1, v, 1'b0, rdy);
    cycle(1'b1, 0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    count_valid = 1'b0; count_in = '0; err_clr = 1'b0; evt_ready = 1'b0;
    model_reset();
    #1;
    check("rst_evt_valid", evt_valid, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_err_jump", err_jump, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    bit cv;
    int cin;
    bit clr;
    bit exp_err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int cur;
    int nxt;
    bit cv_r;
    bit rdy_r;

    vecs[0]  = '{cv:1, cin:5,  clr:0, exp_err:0};  // first sample: load only
    vecs[1]  = '{cv:1, cin:6,  clr:0, exp_err:0};
    vecs[2]  = '{cv:1, cin:9,  clr:0, exp_err:1};  // 6 -> 9 is illegal
    vecs[3]  = '{cv:1, cin:9,  clr:1, exp_err:0};  // hold + clear
    vecs[4]  = '{cv:1, cin:12, clr:0, exp_err:1};
    vecs[5]  = '{cv:1, cin:20, clr:1, exp_err:1};  // jump beats clear
    vecs[6]  = '{cv:0, cin:3,  clr:0, exp_err:1};  // invalid sample ignored
    vecs[7]  = '{cv:1, cin:21, clr:0, exp_err:1};  // legal step, flag sticky
    vecs[8]  = '{cv:1, cin:21, clr:1, exp_err:0};
    vecs[9]  = '{cv:1, cin:22, clr:0, exp_err:0};
    vecs[10] = '{cv:1, cin:23, clr:1, exp_err:0};

    // Jump / clear table.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].cv, vecs[i].cin, vecs[i].clr, 1'b1);
      check($sformatf("tbl_err[%0d]", i), err_jump, vecs[i].exp_err);
      check($sformatf("tbl_valid[%0d]", i), evt_valid, 0);
    end

    // Reset mid-stream, then one clean ramp with the consumer ready.
    do_reset();
    cycle(1'b1, 0, 1'b0, 1'b1);
    for (int v = 1; v <= 31; v++) cycle(1'b1, v, 1'b0, 1'b1);
    check("a_valid_before_wrap", evt_valid, 0);
    cycle(1'b1, 0, 1'b0, 1'b1);
    check("a_valid_after_wrap", evt_valid, 1);
    check("a_seq", evt_seq, 0);
    check("a_ts", evt_ts, 32);
    check("a_err", err_jump, 0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    check("a_valid_after_pop", evt_valid, 0);
    check("a_level_after_pop", fifo_level, 0);

    // Six wraps into a 4-deep FIFO with no consumer.
    do_reset();
    cycle(1'b1, 0, 1'b0, 1'b0);
    for (int w = 0; w < 6; w++) wrap_ramp(1'b0);
    check("b_level_full", fifo_level, 4);
    check("b_drop", drop_cnt, 2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b_drain_seq[%0d]", i), evt_seq, i);
      cycle(1'b0, 0, 1'b0, 1'b1);
    end
    check("b_level_empty", fifo_level, 0);
    wrap_ramp(1'b1);
    check("b_next_seq", evt_seq, 6);

    // Full FIFO with a pop in the same cycle as a wrap.
    cycle(1'b0, 0, 1'b0, 1'b1);
    for (int w = 0; w < 4; w++) wrap_ramp(1'b0);
    check("c_level_full", fifo_level, 4);
    for (int v = 1; v <= 31; v++) cycle(1'b1, v, 1'b0, 1'b0);
    cycle(1'b1, 0, 1'b0, 1'b1);
    check("c_level_kept", fifo_level, 4);
    check("c_drop_kept", drop_cnt, 2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("c_drain_seq[%0d]", i), evt_seq, 8 + i);
      cycle(1'b0, 0, 1'b0, 1'b1);
    end

    // Gaps in count_valid around the wrap, and repeated values.
    do_reset();
    cycle(1'b1, 0, 1'b0, 1'b0);
    for (int v = 1; v <= 31; v++) cycle(1'b1, v, 1'b0, 1'b0);
    cycle(1'b0, 7, 1'b0, 1'b0);
    cycle(1'b0, 3, 1'b0, 1'b0);
    cycle(1'b1, 0, 1'b0, 1'b0);
    check("d_wrap_valid", evt_valid, 1);
    check("d_wrap_seq", evt_seq, 0);
    for (int v = 1; v <= 12; v++) cycle(1'b1, v, 1'b0, 1'b0);
    cycle(1'b1, 12, 1'b0, 1'b0);
    cycle(1'b0, 40, 1'b0, 1'b0);
    cycle(1'b1, 12, 1'b0, 1'b0);
    cycle(1'b1, 13, 1'b0, 1'b0);
    check("d_no_jump", err_jump, 0);

    // Asynchronous reset with three events queued and a nonzero drop count.
    do_reset();
    cycle(1'b1, 0, 1'b0, 1'b0);
    for (int w = 0; w < 5; w++) wrap_ramp(1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    check("e_level_3", fifo_level, 3);
    check("e_drop_1", drop_cnt, 1);
    for (int v = 1; v <= 31; v++) cycle(1'b1, v, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("e_async_valid", evt_valid, 0);
    check("e_async_level", fifo_level, 0);
    check("e_async_drop", drop_cnt, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 0, 1'b0, 1'b1);
    check("e_first_sample_valid", evt_valid, 0);
    check("e_first_sample_level", fifo_level, 0);

    // 300 wraps with no consumer: drop saturation and sequence roll-over.
    do_reset();
    cycle(1'b1, 0, 1'b0, 1'b0);
    for (int w = 0; w < 300; w++) wrap_ramp(1'b0);
    check("f_drop_sat", drop_cnt, 255);
    check("f_level", fifo_level, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("f_drain_seq[%0d]", i), evt_seq, i);
      cycle(1'b0, 0, 1'b0, 1'b1);
    end
    wrap_ramp(1'b1);
    check("f_seq_mod256", evt_seq, 44);
    check("f_drop_still_sat", drop_cnt, 255);

    // Randomized traffic against the model.
    do_reset();
    cur = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6)      nxt = (cur == 31) ? 0 : (cur + 1) % 64;
      else if (r < 8) nxt = cur;
      else            nxt = $urandom_range(0, 63);
      cv_r  = ($urandom_range(0, 3) != 0);
      rdy_r = ($urandom_range(0, 99) < (((i / 200) % 2) ? 15 : 85));
      cycle(cv_r, nxt, ($urandom_range(0, 7) == 0), rdy_r);
      if (cv_r) cur = nxt;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
